ddr_rd_burst_ctrl: RTL

DDR read-burst controller directly upstream of the rotation read cell, in the `ddr_clk` domain. It accepts a single-pulse read request (`ddr_rreq`, `ddr_raddr`, `ddr_rd_len`) and splits it into AXI4 read bursts of at most `BURST_MAX` beats. Returned beats are forwarded as `ddr_rdata`/`ddr_rdata_en`, and `ddr_rdone` is pulsed after the last beat. The consumer's `ddr_rdata_ban` gates the launch of new requests.

---
 rtl/ddr_rd_pkg.sv | 24 ++
 rtl/ddr_rd_req_slot.sv | 64 ++++++
 rtl/ddr_rd_burst_ctrl.sv | 181 ++++++++++++++++++
 3 files changed

// File: rtl/ddr_rd_pkg.sv
// Shared definitions for the DDR read-burst controller: FSM encoding, beat address step
// and a constant clog2 helper.
package ddr_rd_pkg;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_AR,
    ST_RD,
    ST_DONE
  } state_e;

  // Word-address advance per returned beat (one beat spans 8 DQ words).
  localparam int unsigned BEAT_ADDR_STEP = 8;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned result;
    result = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) result = i + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/ddr_rd_req_slot.sv
// One-deep pending request register with full flag and sticky overflow on dropped requests.
// A request arriving in the cycle the slot is popped is loaded in place of the old one.
module ddr_rd_req_slot
  import ddr_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned LEN_WIDTH  = 16
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  req_i,
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic [LEN_WIDTH-1:0]  len_i,
  input  logic                  pop_i,
  output logic                  full_o,
  output logic [ADDR_WIDTH-1:0] addr_o,
  output logic [LEN_WIDTH-1:0]  len_o,
  output logic                  ovf_o
);

  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [LEN_WIDTH-1:0]  len_q, len_d;
  logic                  req_valid;
  logic                  load;

  always_comb begin
    req_valid = req_i && (len_i != '0);
    load      = req_valid && (!full_q || pop_i);
    full_d    = full_q;
    addr_d    = addr_q;
    len_d     = len_q;
    ovf_d     = ovf_q;
    if (load) begin
      full_d = 1'b1;
      addr_d = addr_i;
      len_d  = len_i;
    end else if (pop_i) begin
      full_d = 1'b0;
    end
    if (req_valid && full_q && !pop_i) ovf_d = 1'b1;
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      full_q <= 1'b0;
      ovf_q  <= 1'b0;
      addr_q <= '0;
      len_q  <= '0;
    end else begin
      full_q <= full_d;
      ovf_q  <= ovf_d;
      addr_q <= addr_d;
      len_q  <= len_d;
    end
  end

  assign full_o = full_q;
  assign addr_o = addr_q;
  assign len_o  = len_q;
  assign ovf_o  = ovf_q;

endmodule

// File: rtl/ddr_rd_burst_ctrl.sv
// Splits a single read request into AXI4 read bursts of at most BURST_MAX beats and forwards
// the returned beats. Optional watchdog (rd_timeout port) is enabled by DDR_RD_TIMEOUT_EN.
module ddr_rd_burst_ctrl
  import ddr_rd_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 27,
  parameter int unsigned DQ_WIDTH   = 32,
  parameter int unsigned LEN_WIDTH  = 16,
  parameter int unsigned BURST_MAX  = 16,
  parameter int unsigned TIMEOUT    = 1024
) (
  input  logic                    ddr_clk,
  input  logic                    ddr_rstn,
  input  logic                    ddr_rreq,
  input  logic [ADDR_WIDTH-1:0]   ddr_raddr,
  input  logic [LEN_WIDTH-1:0]    ddr_rd_len,
  input  logic                    ddr_rdata_ban,
  output logic [8*DQ_WIDTH-1:0]   ddr_rdata,
  output logic                    ddr_rdata_en,
  output logic                    ddr_rdone,
  output logic                    busy,
  output logic                    req_ovf,
  output logic [ADDR_WIDTH-1:0]   axi_araddr,
  output logic [7:0]              axi_arlen,
  output logic                    axi_arvalid,
  input  logic                    axi_arready,
  input  logic [8*DQ_WIDTH-1:0]   axi_rdata,
  input  logic                    axi_rvalid,
  input  logic                    axi_rlast,
  output logic                    axi_rready
`ifdef DDR_RD_TIMEOUT_EN
  ,
  output logic                    rd_timeout
`endif
);

  localparam int unsigned BeatShift = clog2(BEAT_ADDR_STEP);

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cur_addr_q, cur_addr_d;
  logic [LEN_WIDTH-1:0]  rem_len_q, rem_len_d;
  logic [8:0]            burst_q, burst_d;
  logic [8:0]            beats;
  logic [8*DQ_WIDTH-1:0] rdata_q;
  logic                  rdata_en_q;
  logic                  rdone_q, rdone_d;
  logic                  slot_full, slot_pop, slot_ovf;
  logic [ADDR_WIDTH-1:0] slot_addr;
  logic [LEN_WIDTH-1:0]  slot_len;
  logic                  tmo_fire;

  ddr_rd_req_slot #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .LEN_WIDTH  (LEN_WIDTH)
  ) u_slot (
    .clk_i  (ddr_clk),
    .rst_ni (ddr_rstn),
    .req_i  (ddr_rreq),
    .addr_i (ddr_raddr),
    .len_i  (ddr_rd_len),
    .pop_i  (slot_pop),
    .full_o (slot_full),
    .addr_o (slot_addr),
    .len_o  (slot_len),
    .ovf_o  (slot_ovf)
  );

  always_comb begin
    if ({1'b0, rem_len_q} >= (LEN_WIDTH + 1)'(BURST_MAX)) beats = 9'(BURST_MAX);
    else                                                  beats = 9'(rem_len_q);
  end

  // Handshake strobes drop combinationally with reset so the AXI side never sees a stale request.
  assign axi_arvalid = ddr_rstn && (state_q == ST_AR);
  assign axi_rready  = ddr_rstn && (state_q == ST_RD);
  assign axi_araddr  = (state_q == ST_AR) ? cur_addr_q : '0;
  assign axi_arlen   = (state_q == ST_AR) ? 8'(beats - 9'd1) : '0;

  always_comb begin
    state_d    = state_q;
    cur_addr_d = cur_addr_q;
    rem_len_d  = rem_len_q;
    burst_d    = burst_q;
    slot_pop   = 1'b0;
    rdone_d    = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (slot_full && !ddr_rdata_ban) begin
          slot_pop   = 1'b1;
          cur_addr_d = slot_addr;
          rem_len_d  = slot_len;
          state_d    = ST_AR;
        end
      end
      ST_AR: begin
        if (axi_arready) begin
          burst_d = beats;
          state_d = ST_RD;
        end
      end
      ST_RD: begin
        // Beat count owns rem_len; rlast alone decides when the burst ends.
        if (axi_rvalid) begin
          if (rem_len_q != '0) rem_len_d = rem_len_q - LEN_WIDTH'(1);
          if (axi_rlast) begin
            cur_addr_d = cur_addr_q + (ADDR_WIDTH'(burst_q) << BeatShift);
            state_d    = (rem_len_d != '0) ? ST_AR : ST_DONE;
          end
        end
      end
      ST_DONE: begin
        rdone_d = 1'b1;
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (tmo_fire) begin
      rdone_d = 1'b1;
      state_d = ST_IDLE;
    end
  end

`ifdef DDR_RD_TIMEOUT_EN
  localparam int unsigned TmoW = clog2(TIMEOUT + 1);

  logic [TmoW-1:0] tmo_q, tmo_d;
  logic            rd_timeout_q;
  logic            any_hs;

  always_comb begin
    any_hs   = (axi_arvalid && axi_arready) || (axi_rready && axi_rvalid);
    tmo_d    = '0;
    tmo_fire = 1'b0;
    if ((state_q inside {ST_AR, ST_RD}) && !any_hs) begin
      if (tmo_q == TmoW'(TIMEOUT - 1)) tmo_fire = 1'b1;
      else                             tmo_d    = tmo_q + TmoW'(1);
    end
  end

  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) begin
      tmo_q        <= '0;
      rd_timeout_q <= 1'b0;
    end else begin
      tmo_q        <= tmo_d;
      rd_timeout_q <= rd_timeout_q | tmo_fire;
    end
  end

  assign rd_timeout = rd_timeout_q;
`else
  assign tmo_fire = 1'b0;
`endif

  always_ff @(posedge ddr_clk) begin
    if (!ddr_rstn) begin
      state_q    <= ST_IDLE;
      cur_addr_q <= '0;
      rem_len_q  <= '0;
      burst_q    <= '0;
      rdata_q    <= '0;
      rdata_en_q <= 1'b0;
      rdone_q    <= 1'b0;
    end else begin
      state_q    <= state_d;
      cur_addr_q <= cur_addr_d;
      rem_len_q  <= rem_len_d;
      burst_q    <= burst_d;
      rdata_en_q <= axi_rvalid && axi_rready;
      if (axi_rvalid && axi_rready) rdata_q <= axi_rdata;
      rdone_q    <= rdone_d;
    end
  end

  assign ddr_rdata    = rdata_q;
  assign ddr_rdata_en = rdata_en_q;
  assign ddr_rdone    = rdone_q;
  assign busy         = (state_q != ST_IDLE);
  assign req_ovf      = slot_ovf;

endmodule
